// File: rtl/shift_pkg.sv
// Shared definitions for the iterative shift controller: op codes, FSM states, default sizes.
package shift_pkg;

  localparam int unsigned DEF_WIDTH   = 32;
  localparam int unsigned DEF_SHAMT_W = 5;
  localparam int unsigned OP_W        = 2;

  localparam logic [OP_W-1:0] OP_SLL = 2'b00;
  localparam logic [OP_W-1:0] OP_SRL = 2'b01;
  localparam logic [OP_W-1:0] OP_SRA = 2'b10;
  localparam logic [OP_W-1:0] OP_ROR = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_DONE  = 2'd2
  } state_e;

endpackage

// File: rtl/iter_shift_ctrl_if.sv
// Request/result handshake bundle between the execute stage (master) and the shift controller (slave).
interface iter_shift_ctrl_if #(
  parameter int unsigned WIDTH   = 32,
  parameter int unsigned SHAMT_W = 5
);

  logic               in_valid;
  logic               in_ready;
  logic [WIDTH-1:0]   in_data;
  logic [SHAMT_W-1:0] in_shamt;
  logic [1:0]         in_op;
  logic               out_valid;
  logic               out_ready;
  logic [WIDTH-1:0]   out_data;

  modport master (
    output in_valid, in_data, in_shamt, in_op, out_ready,
    input  in_ready, out_valid, out_data
  );

  modport slave (
    input  in_valid, in_data, in_shamt, in_op, out_ready,
    output in_ready, out_valid, out_data
  );

endinterface

// File: rtl/shift_one_step.sv
// Combinational single-bit shifter; one call advances the operand by one position for the given op.
module shift_one_step
  import shift_pkg::*;
#(
  parameter int unsigned WIDTH = DEF_WIDTH
) (
  input  logic [OP_W-1:0]  op,
  input  logic [WIDTH-1:0] in,
  output logic [WIDTH-1:0] f
);

  always_comb begin
    f = in;
    case (op)
      OP_SLL: f = {in[WIDTH-2:0], 1'b0};
      OP_SRL: f = {1'b0, in[WIDTH-1:1]};
      OP_SRA: f = {in[WIDTH-1], in[WIDTH-1:1]};
      OP_ROR: f = {in[0], in[WIDTH-1:1]};
    endcase
  end

endmodule

// File: rtl/iter_shift_ctrl.sv
// Multi-cycle shift controller: latches one request, applies one bit of shift per cycle,
// then presents the result on a valid/ready handshake.
module iter_shift_ctrl
  import shift_pkg::*;
#(
  parameter int unsigned WIDTH   = DEF_WIDTH,
  parameter int unsigned SHAMT_W = DEF_SHAMT_W
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic              flush,
  iter_shift_ctrl_if.slave  bus,
  output logic              busy
);

  state_e             state_q, state_d;
  logic [WIDTH-1:0]   data_q, data_d;
  logic [SHAMT_W-1:0] cnt_q, cnt_d;
  logic [OP_W-1:0]    op_q, op_d;
  logic               in_ready_q, out_valid_q, busy_q;
  logic [WIDTH-1:0]   step_data;

  shift_one_step #(.WIDTH(WIDTH)) u_step (
    .op (op_q),
    .in (data_q),
    .f  (step_data)
  );

  // Next-state logic; flush overrides accept and completion but leaves data untouched.
  always_comb begin
    state_d = state_q;
    data_d  = data_q;
    cnt_d   = cnt_q;
    op_d    = op_q;
    unique case (state_q)
      ST_IDLE: begin
        if (bus.in_valid && in_ready_q) begin
          data_d  = bus.in_data;
          cnt_d   = bus.in_shamt;
          op_d    = bus.in_op;
          state_d = (bus.in_shamt == SHAMT_W'(0)) ? ST_DONE : ST_SHIFT;
        end
      end
      ST_SHIFT: begin
        data_d = step_data;
        cnt_d  = cnt_q - SHAMT_W'(1);
        if (cnt_q == SHAMT_W'(1)) begin
          state_d = ST_DONE;
        end
      end
      ST_DONE: begin
        if (bus.out_ready) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
    if (flush) begin
      state_d = ST_IDLE;
      data_d  = data_q;
      cnt_d   = cnt_q;
      op_d    = op_q;
    end
  end

  // Handshake flags are decoded from the next state so they are registered alongside it.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= ST_IDLE;
      data_q      <= '0;
      cnt_q       <= '0;
      op_q        <= OP_SLL;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      data_q      <= data_d;
      cnt_q       <= cnt_d;
      op_q        <= op_d;
      in_ready_q  <= (state_d == ST_IDLE);
      out_valid_q <= (state_d == ST_DONE);
      busy_q      <= (state_d != ST_IDLE);
    end
  end

  assign bus.in_ready  = in_ready_q;
  assign bus.out_valid = out_valid_q;
  assign bus.out_data  = data_q;
  assign busy          = busy_q;

endmodule

// File: tb/tb_iter_shift_ctrl.sv
// Bench for iter_shift_ctrl: arithmetic reference model checked every cycle plus directed literal checks.
module tb_iter_shift_ctrl;

  localparam int unsigned W  = 32;
  localparam int unsigned SW = 5;

  logic clock;
  logic reset_n;
  logic flush;
  logic busy;

  int errors = 0;
  int checks = 0;

  iter_shift_ctrl_if #(.WIDTH(W), .SHAMT_W(SW)) bus ();

  iter_shift_ctrl #(.WIDTH(W), .SHAMT_W(SW)) dut (
    .clock   (clock),
    .reset_n (reset_n),
    .flush   (flush),
    .bus     (bus.slave),
    .busy    (busy)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Full shift of d by k positions, computed directly.
  function automatic logic [31:0] ref_shift(input logic [31:0] d, input logic [1:0] op, input int k);
    logic [31:0] r;
    case (op)
      2'b00:   r = d << k;
      2'b01:   r = d >> k;
      2'b10:   r = 32'($signed(d) >>> k);
      default: r = (k == 0) ? d : ((d >> k) | (d << (32 - k)));
    endcase
    return r;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Reference model: 0 = waiting for request, 1 = working, 2 = result held.
  int          m_ph;
  int          m_n;
  int          m_k;
  logic [31:0] m_src;
  logic [1:0]  m_op;
  logic [31:0] m_data;

  always @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      m_ph = 0; m_n = 0; m_k = 0; m_src = '0; m_op = '0; m_data = '0;
    end else if (flush) begin
      m_ph = 0;
    end else begin
      case (m_ph)
        0: if (bus.in_valid) begin
             m_src  = bus.in_data;
             m_op   = bus.in_op;
             m_n    = int'(bus.in_shamt);
             m_k    = 0;
             m_data = bus.in_data;
             m_ph   = (m_n == 0) ? 2 : 1;
           end
        1: begin
             m_k++;
             m_data = ref_shift(m_src, m_op, m_k);
             if (m_k == m_n) m_ph = 2;
           end
        default: if (bus.out_ready) m_ph = 0;
      endcase
    end
  end

  always @(negedge clock) begin
    chk("cyc_in_ready",  32'(bus.in_ready),  32'(m_ph == 0));
    chk("cyc_out_valid", 32'(bus.out_valid), 32'(m_ph == 2));
    chk("cyc_busy",      32'(busy),          32'(m_ph != 0));
    chk("cyc_out_data",  bus.out_data,       m_data);
  end

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  // Issue one request, wait (bounded) for the result, check latency and value.
  task automatic run_op(input string name, input logic [31:0] d, input logic [4:0] n,
                        input logic [1:0] op, input logic [31:0] exp, input int exp_lat);
    int lat;
    bus.in_valid = 1'b1;
    bus.in_data  = d;
    bus.in_shamt = n;
    bus.in_op    = op;
    tick();
    bus.in_valid = 1'b0;
    lat = 1;
    while (!bus.out_valid && lat < 100) begin
      tick();
      lat++;
    end
    chk({name, "_lat"},  32'(lat), 32'(exp_lat));
    chk({name, "_data"}, bus.out_data, exp);
    if (bus.out_ready) tick();
  endtask

  initial begin
    logic [31:0] held;
    reset_n       = 1'b0;
    flush         = 1'b0;
    bus.in_valid  = 1'b0;
    bus.in_data   = '0;
    bus.in_shamt  = '0;
    bus.in_op     = '0;
    bus.out_ready = 1'b1;
    tick();
    chk("rst_in_ready",  32'(bus.in_ready),  32'd1);
    chk("rst_out_valid", 32'(bus.out_valid), 32'd0);
    chk("rst_busy",      32'(busy),          32'd0);
    chk("rst_out_data",  bus.out_data,       32'h0);
    tick();
    reset_n = 1'b1;
    tick();

    run_op("sra4",   32'h8000_0000, 5'd4,  2'b10, 32'hF800_0000, 5);
    run_op("srl31",  32'h8000_0000, 5'd31, 2'b01, 32'h0000_0001, 32);
    run_op("sll0",   32'h0000_0001, 5'd0,  2'b00, 32'h0000_0001, 1);
    run_op("ror1",   32'h0000_0001, 5'd1,  2'b11, 32'h8000_0000, 2);
    run_op("sra31",  32'h7FFF_FFFF, 5'd31, 2'b10, 32'h0000_0000, 32);
    run_op("ror4",   32'h0000_00A5, 5'd4,  2'b11, 32'h5000_000A, 5);

    // Backpressure: result held while out_ready is low.
    bus.out_ready = 1'b0;
    run_op("bp", 32'h0000_00F0, 5'd3, 2'b00, 32'h0000_0780, 4);
    held = bus.out_data;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("bp_hold_data",  bus.out_data,       held);
      chk("bp_hold_ready", 32'(bus.in_ready),  32'd0);
      chk("bp_hold_busy",  32'(busy),          32'd1);
      chk("bp_hold_valid", 32'(bus.out_valid), 32'd1);
    end
    bus.out_ready = 1'b1;
    tick();
    chk("bp_release_ready", 32'(bus.in_ready),  32'd1);
    chk("bp_release_valid", 32'(bus.out_valid), 32'd0);

    // Flush with two steps left of an 8-step shift.
    bus.in_valid = 1'b1;
    bus.in_data  = 32'hFFFF_0000;
    bus.in_shamt = 5'd8;
    bus.in_op    = 2'b01;
    tick();
    bus.in_valid = 1'b0;
    for (int i = 0; i < 6; i++) tick();
    flush = 1'b1;
    tick();
    flush = 1'b0;
    chk("flush_ready", 32'(bus.in_ready),  32'd1);
    chk("flush_valid", 32'(bus.out_valid), 32'd0);
    chk("flush_data",  bus.out_data,       32'h03FF_FC00);
    run_op("post_flush_ror", 32'h0000_0001, 5'd1, 2'b11, 32'h8000_0000, 2);

    // Asynchronous reset in the middle of a shift.
    bus.in_valid = 1'b1;
    bus.in_data  = 32'hAAAA_5555;
    bus.in_shamt = 5'd20;
    bus.in_op    = 2'b01;
    tick();
    bus.in_valid = 1'b0;
    for (int i = 0; i < 5; i++) tick();
    #1;
    reset_n = 1'b0;
    #1;
    chk("arst_in_ready",  32'(bus.in_ready),  32'd1);
    chk("arst_out_valid", 32'(bus.out_valid), 32'd0);
    chk("arst_busy",      32'(busy),          32'd0);
    chk("arst_out_data",  bus.out_data,       32'h0);
    tick();
    reset_n = 1'b1;
    tick();
    run_op("sll2", 32'h0000_0003, 5'd2, 2'b00, 32'h0000_000C, 3);

    tick();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
